// File: rtl/clkdiv_pkg.sv
// Shared definitions for the clock-divide sequencer: select encoding,
// select-to-count mapping and FSM state encoding.
package clkdiv_pkg;

    localparam logic [1:0] SEL_DIV2  = 2'b00;
    localparam logic [1:0] SEL_DIV4  = 2'b01;
    localparam logic [1:0] SEL_DIV8  = 2'b11;
    localparam logic [1:0] SEL_DIV16 = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    // Terminal count T = N-1 for the divide ratio selected by sel.
    function automatic logic [3:0] sel_to_term(input logic [1:0] sel);
        logic [3:0] t;
        case (sel)
            SEL_DIV2: t = 4'd1;
            SEL_DIV4: t = 4'd3;
            SEL_DIV8: t = 4'd7;
            default:  t = 4'd15;
        endcase
        return t;
    endfunction

    // Half period N/2: div_out is high for count values at or above this.
    function automatic logic [3:0] sel_to_half(input logic [1:0] sel);
        logic [3:0] h;
        case (sel)
            SEL_DIV2: h = 4'd1;
            SEL_DIV4: h = 4'd2;
            SEL_DIV8: h = 4'd4;
            default:  h = 4'd8;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/clkdiv_counter.sv
// Divide counter: counts while inc is high, wraps to 0 after term,
// synchronous clear has priority. cnt_nxt exposes the value loaded next edge.
module clkdiv_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] term,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_nxt,
    output logic             wrap
);

    assign wrap = (cnt == term);

    always_comb begin
        cnt_nxt = cnt;
        if (clr) begin
            cnt_nxt = '0;
        end else if (inc) begin
            cnt_nxt = wrap ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/clkdiv_sched.sv
// Clock-divide sequencer: divided tick and 50% level for /2../16 in the clk
// domain; ratio changes land on period boundaries. Optional macro
// CLKDIV_SCHED_TICK_CNT_EN adds a saturating tick_count output.
module clkdiv_sched
    import clkdiv_pkg::*;
#(
    parameter logic [1:0] RESET_SEL = 2'b00,
    parameter int         CNT_W     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       sel_req_valid,
    input  logic [1:0] sel_req,
    output logic       sel_req_ready,
    output logic [1:0] sel_cur,
    output logic       tick,
    output logic       div_out,
    output logic       switch_done,
`ifdef CLKDIV_SCHED_TICK_CNT_EN
    output logic [15:0] tick_count,
`endif
    output logic [1:0] state_dbg
);

    // Request handshake: a select is taken on a cycle where sel_req_valid and
    // sel_req_ready are both high; sel_req is only looked at on that cycle and
    // ready is a pure state decode (low only while a select is pending).

    state_t           state, nxt_state;
    logic [1:0]       pend_sel, nxt_pend;
    logic [1:0]       nxt_sel;
    logic             accept;
    logic             apply;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             wrap;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] term_cur;
    logic [CNT_W-1:0] term_nxt;
    logic [CNT_W-1:0] half_nxt;
    logic             tick_d;
    logic             div_d;

    assign sel_req_ready = (state != PEND);
    assign accept        = sel_req_valid && sel_req_ready;
    assign state_dbg     = state;

    always_comb begin
        nxt_state = state;
        nxt_sel   = sel_cur;
        nxt_pend  = pend_sel;
        apply     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    nxt_sel = sel_req;
                    apply   = 1'b1;
                end
                if (en) begin
                    nxt_state = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    // An accepted request is not lost when the run stops.
                    nxt_state = IDLE;
                    if (accept) begin
                        nxt_sel = sel_req;
                        apply   = 1'b1;
                    end
                end else if (accept) begin
                    nxt_state = PEND;
                    nxt_pend  = sel_req;
                end
            end
            PEND: begin
                if (!en) begin
                    nxt_state = IDLE;
                    nxt_sel   = pend_sel;
                    apply     = 1'b1;
                end else if (wrap) begin
                    nxt_state = RUN;
                    nxt_sel   = pend_sel;
                    apply     = 1'b1;
                end
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    // A new select always restarts the period from zero.
    assign cnt_clr  = (nxt_state == IDLE) || apply;
    assign cnt_inc  = (state != IDLE);
    assign term_cur = CNT_W'(sel_to_term(sel_cur));
    assign term_nxt = CNT_W'(sel_to_term(nxt_sel));
    assign half_nxt = CNT_W'(sel_to_half(nxt_sel));

    clkdiv_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .term    (term_cur),
        .cnt     (cnt),
        .cnt_nxt (cnt_nxt),
        .wrap    (wrap)
    );

    // Outputs are registered from next-cycle values so they line up with cnt.
    assign tick_d = (nxt_state != IDLE) && (cnt_nxt == term_nxt);
    assign div_d  = (nxt_state != IDLE) && (cnt_nxt >= half_nxt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sel_cur     <= RESET_SEL;
            pend_sel    <= RESET_SEL;
            tick        <= 1'b0;
            div_out     <= 1'b0;
            switch_done <= 1'b0;
        end else begin
            state       <= nxt_state;
            sel_cur     <= nxt_sel;
            pend_sel    <= nxt_pend;
            tick        <= tick_d;
            div_out     <= div_d;
            switch_done <= apply;
        end
    end

`ifdef CLKDIV_SCHED_TICK_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_count <= 16'h0000;
        end else if (apply) begin
            tick_count <= 16'h0000;
        end else if (tick_d && (tick_count != 16'hFFFF)) begin
            tick_count <= tick_count + 16'h0001;
        end
    end
`endif

endmodule
